// File: rtl/da_vinci_run_ctrl.sv
// da_vinci_run_ctrl
//   Run/dump sequencer for the DA_VINCI system. It holds the processor in
//   reset for RST_CYCLES, lets it run until HALT or the cycle budget expires,
//   parks it back in reset, then takes the memory bus and streams the window
//   DUMP_BASE .. DUMP_BASE+DUMP_WORDS-1 out through a valid/ready port.
//
// Ports
//   CLK, RST           clock (rising edge), async active-low reset
//   HALT               processor halt indication, sampled in RUN only
//   CPU_RST            active-low reset to the processor
//   MEM_GRANT          controller owns the memory bus
//   MEM_ADDR/MEM_READ  dump read request, 1-cycle read latency
//   MEM_DATA_IN        memory read data
//   DUMP_VALID/READY   dump stream handshake
//   DUMP_ADDR/DATA     presented dump word and its address
//   CYCLE_COUNT        cycles spent in RUN (saturating, frozen after RUN)
//   TIMEOUT            run ended by budget rather than HALT
//   DONE               sequence complete
module da_vinci_run_ctrl #(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 32,
  parameter int                    RST_CYCLES = 5,
  parameter int                    RUN_CYCLES = 500,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE  = 26'h1000000,
  parameter int                    DUMP_WORDS = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  HALT,
  output logic                  CPU_RST,
  output logic                  MEM_GRANT,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
  output logic                  DUMP_VALID,
  input  logic                  DUMP_READY,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic [CNT_WIDTH-1:0]  CYCLE_COUNT,
  output logic                  TIMEOUT,
  output logic                  DONE
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int IDX_W  = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);
  localparam logic [CNT_WIDTH:0] BUDGET    = (CNT_WIDTH+1)'(RUN_CYCLES);

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_REQ, S_WAIT, S_OUT, S_FIN} state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [CNT_WIDTH:0]  cnt_inc;
  logic                budget_hit;

  assign idx_nxt    = idx + 1'b1;
  // One extra bit so a saturated counter never aliases onto a small budget.
  assign cnt_inc    = {1'b0, CYCLE_COUNT} + 1'b1;
  assign budget_hit = (RUN_CYCLES != 0) && (cnt_inc == BUDGET);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      idx         <= '0;
      CPU_RST     <= 1'b0;
      MEM_GRANT   <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_READ    <= 1'b0;
      DUMP_VALID  <= 1'b0;
      DUMP_ADDR   <= '0;
      DUMP_DATA   <= '0;
      CYCLE_COUNT <= '0;
      TIMEOUT     <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            CPU_RST <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // The exit cycle itself is counted.
          if (CYCLE_COUNT != '1) CYCLE_COUNT <= CYCLE_COUNT + 1'b1;
          if (HALT || budget_hit) begin
            TIMEOUT   <= !HALT;  // HALT wins a tie with the budget
            CPU_RST   <= 1'b0;
            MEM_GRANT <= 1'b1;
            if (DUMP_WORDS == 0) begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end else begin
              state    <= S_REQ;
              MEM_READ <= 1'b1;
              MEM_ADDR <= DUMP_BASE;
            end
          end
        end
        S_REQ: begin
          MEM_READ <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Read data arrives the cycle after the strobe.
          DUMP_DATA  <= MEM_DATA_IN;
          DUMP_ADDR  <= MEM_ADDR;
          DUMP_VALID <= 1'b1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (DUMP_READY) begin
            DUMP_VALID <= 1'b0;
            if (idx == IDX_LAST) begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              MEM_READ <= 1'b1;
              MEM_ADDR <= DUMP_BASE + ADDR_WIDTH'(idx_nxt);  // wraps silently
              state    <= S_REQ;
            end
          end
        end
        S_FIN: ;
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
